mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sub-word load/store engine between the multicycle CPU datapath and a word-wide data memory with a req/ack handshake.
- Loads: fetches the aligned word, extracts the byte or halfword lane, and sign- or zero-extends it to 32 bits.
- Stores: a byte/halfword store performs a read-modify-write, merging the new lane into the fetched word.
- Sits between the MEM-stage control FSM and the data memory port.

Parameters:
- MAX_WAIT, 16, maximum cycles spent in READ or WRITE waiting for mem_ack before aborting with timeout (≥1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- is_signed  in  1  load extension: 1 sign, 0 zero; ignored for stores and word loads
- addr  in  32  byte address
- wdata  in  32  store data; byte uses [7:0], halfword uses [15:0]
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse
- misalign  out  1  qualifies done: alignment or reserved-size error
- timeout  out  1  qualifies done: ack wait exceeded MAX_WAIT
- rdata  out  32  extended load result; held until the next successful load
- mem_req  out  1  memory request, held until acked
- mem_we  out  1  1 = write cycle
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_wdata  out  32  write word
- mem_rdata  in  32  read word, valid with mem_ack
- mem_ack  in  1  transfer complete; may rise in the same cycle as mem_req

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - busy, done, misalign, timeout, mem_req, mem_we = 0.
  - rdata, mem_addr, mem_wdata = 0.
  - wait counter = 0.
  - Reset mid-transaction aborts immediately; no done pulse is produced.
- Endianness is little-endian: lane = addr[1:0]; the byte occupies bits [8*lane+7 : 8*lane]; the halfword occupies bits [16*addr[1]+15 : 16*addr[1]].
- States: IDLE, CHECK, READ, WRITE, DONE.
- IDLE: on start, latch is_store, size, is_signed, addr, wdata; go to CHECK. start in any other state is ignored.
- CHECK (1 cycle): classify the latched request.
  - Error if size == 11, or halfword with addr[0] == 1, or word with addr[1:0] != 0. On error, set misalign and go to DONE; no memory access is made.
  - Word store goes to WRITE.
  - Every other request goes to READ.
- READ: mem_req = 1, mem_we = 0, mem_addr = aligned address.
  - On mem_ack, capture mem_rdata.
  - For a load: compute rdata from the captured word, then go to DONE.
  - For a store: build mem_wdata = captured word with the target lane replaced by wdata's low bits; other lanes unchanged. Go to WRITE.
- WRITE: mem_req = 1, mem_we = 1, mem_wdata stable. On mem_ack, go to DONE.
- mem_req stays high across the READ→WRITE transition. It drops on the cycle after the final ack.
- Wait counter:
  - Clears on entry to READ and to WRITE; increments each cycle without ack.
  - If it reaches MAX_WAIT with no ack, set timeout, drop mem_req, and go to DONE.
  - An ack on the same cycle the limit is reached wins; no timeout.
- DONE (1 cycle): done = 1 with misalign/timeout valid, then return to IDLE. misalign and timeout clear on the next start.
- mem_ack outside READ/WRITE is ignored.
- Load extension:
  - Byte: signed fills bits [31:8] with lane bit 7; unsigned fills with 0.
  - Halfword: signed fills bits [31:16] with bit 15; unsigned fills with 0.
  - Word: rdata = mem_rdata.
- rdata updates only on a successful load. Errors and stores leave it unchanged.
- Latency with zero-wait memory (ack in the same cycle as req), counted from the start cycle to the done cycle:
  - load = 3 cycles
  - word store = 3 cycles
  - sub-word store = 4 cycles
  - error = 2 cycles

Test Plan:
- Load byte, signed: memory word at 0x100 = 0x12F4_5680; addr = 0x103 → rdata = 0x0000_0012. Same word, addr = 0x102, signed → rdata = 0xFFFF_FFF4; unsigned → 0x0000_00F4. done pulses at start + 3.
- Load halfword: word = 0x8001_7FFF. addr = 0x102, signed → 0xFFFF_8001. addr = 0x100, unsigned → 0x0000_7FFF.
- Store byte RMW: word = 0xAABB_CCDD; store byte 0x11 to addr = 0x101.
  - Bus shows a read, then a write of 0xAABB_11DD with mem_req continuous.
  - done at start + 4 with zero-wait memory.
- Misaligned accesses:
  - Halfword load at 0x101 → done + misalign at start + 2, mem_req never asserted, rdata unchanged.
  - Word store at 0x102 → same response.
  - size = 11 → same response.
- Timeout: MAX_WAIT = 4, mem_ack held at 0 → done + timeout on the cycle after the 4th wait cycle, mem_req low afterwards. A second run with ack on the 4th cycle → normal completion.
- Async reset mid-WRITE with a delayed ack:
  - All outputs return to 0 immediately; no done pulse.
  - A subsequent word load at 0x0 completes normally.
  - A start pulse issued while busy is ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// Sub-word load/store engine between the CPU MEM stage and a word-wide data memory.
// Latency (zero-wait memory, start to done): load 3, word store 3, sub-word store 4, error 2 cycles.
// Backpressure: mem_req is held until mem_ack; ack waits longer than MAX_WAIT cycles abort with timeout.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   start, is_store, size, is_signed request; sampled only while idle
//   addr, wdata                      byte address and store data
//   busy, done, misalign, timeout    status; misalign/timeout qualify the done pulse
//   rdata                            extended load result, held until the next successful load
//   mem_req/we/addr/wdata            memory request side
//   mem_rdata, mem_ack               memory response side
module mem_access_unit #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic        timeout,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_WRITE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          store_q, store_d;
  logic [1:0]    size_q, size_d;
  logic          signed_q, signed_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          misalign_q, misalign_d;
  logic          timeout_q, timeout_d;

  // Datapath helpers: lane extraction and read-modify-write merge.
  logic        req_err;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_src, half_src;
  logic [31:0] load_val;
  logic [31:0] lane_mask, lane_data, merged;

  always_comb begin
    req_err = (size_q == 2'b11) ||
              (size_q == 2'b01 && lane_q[0]) ||
              (size_q == 2'b10 && lane_q != 2'b00);

    byte_sh  = {lane_q, 3'b000};
    half_sh  = {lane_q[1], 4'b0000};
    byte_src = mem_rdata >> byte_sh;
    half_src = mem_rdata >> half_sh;

    case (size_q)
      2'b00:   load_val = {{24{signed_q & byte_src[7]}}, byte_src[7:0]};
      2'b01:   load_val = {{16{signed_q & half_src[15]}}, half_src[15:0]};
      default: load_val = mem_rdata;
    endcase

    if (size_q == 2'b00) begin
      lane_mask = 32'h0000_00FF << byte_sh;
      lane_data = {24'h0, wdata_q[7:0]} << byte_sh;
    end else begin
      lane_mask = 32'h0000_FFFF << half_sh;
      lane_data = {16'h0, wdata_q[15:0]} << half_sh;
    end
    merged = (mem_rdata & ~lane_mask) | lane_data;
  end

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    size_d      = size_q;
    signed_d    = signed_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    misalign_d  = misalign_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          store_d    = is_store;
          size_d     = size;
          signed_d   = is_signed;
          lane_d     = addr[1:0];
          wdata_d    = wdata;
          mem_addr_d = {addr[31:2], 2'b00};
          misalign_d = 1'b0;
          timeout_d  = 1'b0;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (req_err) begin
          misalign_d = 1'b1;
          state_d    = S_DONE;
        end else if (store_q && size_q == 2'b10) begin
          mem_wdata_d = wdata_q;
          state_d     = S_WRITE;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        // An ack in the same cycle as the wait limit takes priority.
        if (mem_ack) begin
          cnt_d = '0;
          if (store_q) begin
            mem_wdata_d = merged;
            state_d     = S_WRITE;
          end else begin
            rdata_d = load_val;
            state_d = S_DONE;
          end
        end else if (cnt_q == LAST_WAIT) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          state_d = S_DONE;
        end else if (cnt_q == LAST_WAIT) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
    end
  end

  // The request is a pure function of state, so it stays high across READ->WRITE
  // and drops in DONE, the cycle after the final ack or timeout.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_req   = (state_q == S_READ) || (state_q == S_WRITE);
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign misalign  = misalign_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_store, is_signed;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, misalign, timeout;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  mem_access_unit #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .size(size),
    .is_signed(is_signed), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .misalign(misalign), .timeout(timeout), .rdata(rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Memory model: ack after ack_dly cycles of request, or never when ack_block is set.
  logic [31:0] mem [0:255];
  logic [7:0]  req_cnt = 8'd0;
  logic [7:0]  ack_dly = 8'd0;
  logic        ack_block = 1'b0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_dat = 32'd0;
  int          req_cycles = 0;
  int          done_cycles = 0;

  assign mem_ack   = mem_req && !ack_block && (req_cnt >= ack_dly);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (!mem_req || mem_ack) req_cnt <= 8'd0;
    else                     req_cnt <= req_cnt + 8'd1;
    if (mem_req) req_cycles <= req_cycles + 1;
    if (done)    done_cycles <= done_cycles + 1;
    if (pl_en) mem[pl_idx] <= pl_dat;
    else if (mem_req && mem_we && mem_ack) mem[mem_addr[9:2]] <= mem_wdata;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] dat);
    @(negedge clk);
    pl_idx = idx; pl_dat = dat; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Leaves the bench at the negedge of cycle 1 (start was sampled at cycle 0).
  task automatic launch(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    is_store = st; size = sz; is_signed = sg; addr = a; wdata = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic op(input string tag, input logic st, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                    input logic exp_mis, input logic exp_to, input logic [31:0] exp_rd);
    int lat;
    launch(st, sz, sg, a, d);
    wait_done(1, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_misalign"}, {31'd0, misalign}, {31'd0, exp_mis});
    check({tag, "_timeout"}, {31'd0, timeout}, {31'd0, exp_to});
    check({tag, "_rdata"}, rdata, exp_rd);
  endtask

  initial begin
    int lat;
    int rq0, dn0;
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; size = 2'b00; is_signed = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_flags", {30'd0, misalign, timeout}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_mwdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    // Byte loads, little-endian lanes
    poke(8'h40, 32'h12F4_5680);
    op("lb_103_s", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 3, 1'b0, 1'b0, 32'h0000_0012);
    op("lb_102_s", 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 3, 1'b0, 1'b0, 32'hFFFF_FFF4);
    op("lb_102_u", 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 3, 1'b0, 1'b0, 32'h0000_00F4);
    op("lb_100_s", 1'b0, 2'b00, 1'b1, 32'h100, 32'h0, 3, 1'b0, 1'b0, 32'hFFFF_FF80);

    // Halfword loads
    poke(8'h40, 32'h8001_7FFF);
    op("lh_102_s", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 3, 1'b0, 1'b0, 32'hFFFF_8001);
    op("lh_100_u", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 3, 1'b0, 1'b0, 32'h0000_7FFF);

    // Byte store read-modify-write, bus watched cycle by cycle
    poke(8'h40, 32'hAABB_CCDD);
    launch(1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFF_FF11);
    check("sb_c1_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check("sb_c2_req_we", {30'd0, mem_req, mem_we}, 32'd2);
    check("sb_c2_addr", mem_addr, 32'h100);
    @(negedge clk);
    check("sb_c3_req_we", {30'd0, mem_req, mem_we}, 32'd3);
    check("sb_c3_wdata", mem_wdata, 32'hAABB_11DD);
    @(negedge clk);
    check("sb_c4_done_req", {30'd0, done, mem_req}, 32'd2);
    check("sb_mem", mem[8'h40], 32'hAABB_11DD);
    check("sb_rdata_kept", rdata, 32'h0000_7FFF);

    // Halfword store to upper lane, then word store and word load
    op("sh_102", 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_BEEF, 4, 1'b0, 1'b0, 32'h0000_7FFF);
    check("sh_mem", mem[8'h40], 32'hBEEF_11DD);
    op("sw_104", 1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFE_F00D, 3, 1'b0, 1'b0, 32'h0000_7FFF);
    check("sw_mem", mem[8'h41], 32'hCAFE_F00D);
    op("lw_104", 1'b0, 2'b10, 1'b1, 32'h104, 32'h0, 3, 1'b0, 1'b0, 32'hCAFE_F00D);

    // Errors: no memory access, rdata untouched
    rq0 = req_cycles;
    op("lh_101_mis", 1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 2, 1'b1, 1'b0, 32'hCAFE_F00D);
    op("sw_102_mis", 1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 2, 1'b1, 1'b0, 32'hCAFE_F00D);
    op("sz11_mis", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 2, 1'b1, 1'b0, 32'hCAFE_F00D);
    @(negedge clk);
    check("mis_no_req", 32'(req_cycles - rq0), 32'd0);
    check("mis_mem", mem[8'h41], 32'hCAFE_F00D);

    // Timeout with MAX_WAIT=4, then ack on the 4th wait cycle
    poke(8'h40, 32'h0BAD_BEEF);
    ack_block = 1'b1;
    op("lw_timeout", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 6, 1'b0, 1'b1, 32'hCAFE_F00D);
    check("to_req_low", {31'd0, mem_req}, 32'd0);
    ack_block = 1'b0;
    ack_dly = 8'd3;
    op("lw_ack4", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 6, 1'b0, 1'b0, 32'h0BAD_BEEF);

    // Async reset in WRITE while the ack is still pending
    poke(8'h42, 32'h2222_2222);
    ack_dly = 8'd5;
    dn0 = done_cycles;
    launch(1'b1, 2'b10, 1'b0, 32'h108, 32'h1357_9BDF);
    @(negedge clk);
    @(negedge clk);
    check("rw_in_write", {30'd0, mem_req, mem_we}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("rw_busy_req", {29'd0, busy, mem_req, mem_we}, 32'd0);
    check("rw_maddr", mem_addr, 32'd0);
    check("rw_mwdata", mem_wdata, 32'd0);
    check("rw_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rw_no_done", 32'(done_cycles - dn0), 32'd0);
    check("rw_mem_untouched", mem[8'h42], 32'h2222_2222);

    // Word load at 0 with a start pulse while busy that must be ignored
    ack_dly = 8'd0;
    poke(8'h00, 32'h5A5A_1234);
    poke(8'h01, 32'h1111_1111);
    launch(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    is_store = 1'b1; size = 2'b10; addr = 32'h4; wdata = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, lat);
    check("lw0_lat", 32'(lat), 32'd3);
    check("lw0_rdata", rdata, 32'h5A5A_1234);
    check("lw0_flags", {30'd0, misalign, timeout}, 32'd0);
    repeat (2) @(negedge clk);
    check("busy_start_ignored", {31'd0, busy}, 32'd0);
    check("busy_start_mem", mem[8'h01], 32'h1111_1111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
